except_ctrl: RTL and testbench



---
 rtl/cpu_except_pkg.sv | 44 ++++
 rtl/except_prio_enc.sv | 44 ++++
 rtl/except_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_except_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_except_pkg.sv
// Shared exception definitions: excepttype codes, CP0 register addresses,
// status/cause bit positions and the arbiter FSM state type.
package cpu_except_pkg;

  localparam logic [4:0] EXC_NONE    = 5'h00;
  localparam logic [4:0] EXC_SYSCALL = 5'h09;
  localparam logic [4:0] EXC_RI      = 5'h0a;
  localparam logic [4:0] EXC_OV      = 5'h0b;
  localparam logic [4:0] EXC_TRAP    = 5'h0c;
  localparam logic [4:0] EXC_ERET    = 5'h0d;

  localparam logic [4:0] CP0_STATUS = 5'h0c;
  localparam logic [4:0] CP0_CAUSE  = 5'h0d;
  localparam logic [4:0] CP0_EPC    = 5'h0e;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_LSB     = 8;
  localparam int IM_MSB     = 15;

  localparam int FLAG_SYSCALL = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_TRAP    = 3;
  localparam int FLAG_ERET    = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Interrupt code is the index of the lowest pending line plus one.
  function automatic logic [4:0] lowest_int_code(input logic [7:0] ip);
    logic [4:0] code;
    code = EXC_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (ip[i]) begin
        code = 5'(i + 1);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/except_prio_enc.sv
// Combinational priority encoder: interrupt > ri > ov > trap > syscall > eret.
module except_prio_enc
  import cpu_except_pkg::*;
(
  input  logic       valid_i,
  input  logic [4:0] flags_i,
  input  logic [7:0] ip_i,
  input  logic       ie_i,
  input  logic       exl_i,
  output logic       hit_o,
  output logic [4:0] code_o
);

  always_comb begin
    hit_o  = 1'b0;
    code_o = EXC_NONE;
    if (!valid_i) begin
      hit_o  = 1'b0;
      code_o = EXC_NONE;
    end else if ((ip_i != 8'h00) && ie_i && !exl_i) begin
      hit_o  = 1'b1;
      code_o = lowest_int_code(ip_i);
    end else if (flags_i[FLAG_RI]) begin
      hit_o  = 1'b1;
      code_o = EXC_RI;
    end else if (flags_i[FLAG_OV]) begin
      hit_o  = 1'b1;
      code_o = EXC_OV;
    end else if (flags_i[FLAG_TRAP]) begin
      hit_o  = 1'b1;
      code_o = EXC_TRAP;
    end else if (flags_i[FLAG_SYSCALL]) begin
      hit_o  = 1'b1;
      code_o = EXC_SYSCALL;
    end else if (flags_i[FLAG_ERET]) begin
      hit_o  = 1'b1;
      code_o = EXC_ERET;
    end else begin
      hit_o  = 1'b0;
      code_o = EXC_NONE;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception/interrupt arbiter feeding CP0 and the fetch redirect.
// Define EXCEPT_CTRL_INT_SYNC_EN to pass int_i through a 2-flop synchronizer.
module except_ctrl
  import cpu_except_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_slot_i,
  input  logic [4:0]  exc_flags_i,
  input  logic [7:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_delay_slot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic        ds_q, ds_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        busy_q, busy_d;

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic [7:0]  int_src, int_line, ip;
  logic        hit;
  logic [4:0]  code;

`ifdef EXCEPT_CTRL_INT_SYNC_EN
  logic [7:0] int_s1_q, int_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_s1_q <= 8'h00;
      int_s2_q <= 8'h00;
    end else begin
      int_s1_q <= int_i;
      int_s2_q <= int_s1_q;
    end
  end

  assign int_src = int_s2_q;
`else
  assign int_src = int_i;
`endif

  // Forward an in-flight WB mtc0 so the decision sees the newest CP0 value.
  always_comb begin
    status_eff = status_i;
    cause_eff  = cause_i;
    epc_eff    = epc_i;
    if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_STATUS)) begin
      status_eff = wb_cp0_wdata_i;
    end else if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_CAUSE)) begin
      cause_eff = wb_cp0_wdata_i;
    end else if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_EPC)) begin
      epc_eff = wb_cp0_wdata_i;
    end else begin
      status_eff = status_i;
    end
  end

  assign int_line = {int_src[7] | timer_int_i, int_src[6:0]};
  assign ip       = (cause_eff[IM_MSB:IM_LSB] | int_line) & status_eff[IM_MSB:IM_LSB];

  except_prio_enc u_prio (
    .valid_i (valid_i),
    .flags_i (exc_flags_i),
    .ip_i    (ip),
    .ie_i    (status_eff[STATUS_IE]),
    .exl_i   (status_eff[STATUS_EXL]),
    .hit_o   (hit),
    .code_o  (code)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      code_q   <= EXC_NONE;
      exc_pc_q <= 32'h0000_0000;
      ds_q     <= 1'b0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0000_0000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      exc_pc_q <= exc_pc_d;
      ds_q     <= ds_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are registered; the code is a single-cycle pulse, the rest hold through FLUSH.
  always_comb begin
    code_d   = EXC_NONE;
    exc_pc_d = exc_pc_q;
    ds_d     = ds_q;
    flush_d  = flush_q;
    new_pc_d = new_pc_q;
    busy_d   = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          code_d   = code;
          exc_pc_d = pc_i;
          ds_d     = in_delay_slot_i;
          flush_d  = 1'b1;
          new_pc_d = (code == EXC_ERET) ? epc_eff : EXC_VECTOR;
        end else begin
          flush_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          flush_d = 1'b0;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: begin
        flush_d = 1'b0;
      end
    endcase
  end

  assign excepttype_o     = {27'd0, code_q};
  assign exc_pc_o         = exc_pc_q;
  assign exc_delay_slot_o = ds_q;
  assign flush_o          = flush_q;
  assign new_pc_o         = new_pc_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl (default build, plus a FLUSH_CYCLES=1 copy).
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        in_delay_slot_i;
  logic [4:0]  exc_flags_i;
  logic [7:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;

  logic [31:0] excepttype_o, exc_pc_o, new_pc_o;
  logic        exc_delay_slot_o, flush_o, busy_o;
  logic [31:0] excepttype_1, exc_pc_1, new_pc_1;
  logic        exc_delay_slot_1, flush_1, busy_1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  except_ctrl dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .pc_i(pc_i),
    .in_delay_slot_i(in_delay_slot_i), .exc_flags_i(exc_flags_i), .int_i(int_i),
    .timer_int_i(timer_int_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o), .exc_delay_slot_o(exc_delay_slot_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  except_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .pc_i(pc_i),
    .in_delay_slot_i(in_delay_slot_i), .exc_flags_i(exc_flags_i), .int_i(int_i),
    .timer_int_i(timer_int_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_wdata_i(wb_cp0_wdata_i),
    .excepttype_o(excepttype_1), .exc_pc_o(exc_pc_1), .exc_delay_slot_o(exc_delay_slot_1),
    .flush_o(flush_1), .new_pc_o(new_pc_1), .busy_o(busy_1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    valid_i = 1'b0; pc_i = 32'h0; in_delay_slot_i = 1'b0; exc_flags_i = 5'h00;
    int_i = 8'h00; timer_int_i = 1'b0; status_i = 32'h0; cause_i = 32'h0; epc_i = 32'h0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'h00; wb_cp0_wdata_i = 32'h0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    quiet();
    reset_n = 1'b0;
    #2;
    check_eq("rst_exctype", excepttype_o, 32'h0);
    check_eq("rst_flush", {31'd0, flush_o}, 32'h0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'h0);
    step(2);
    reset_n = 1'b1;
    step(1);

    // Interrupt on line 2 -> code 3, 2-cycle flush; FLUSH_CYCLES=1 copy flushes one cycle.
    status_i = 32'h1000_ff01; int_i = 8'h04; valid_i = 1'b1; pc_i = 32'h100;
    step(1);
    check_eq("int_code", excepttype_o, 32'h3);
    check_eq("int_pc", exc_pc_o, 32'h100);
    check_eq("int_newpc", new_pc_o, 32'h40);
    check_eq("int_flush1", {31'd0, flush_o}, 32'h1);
    check_eq("int_busy", {31'd0, busy_o}, 32'h1);
    check_eq("f1_flush_a", {31'd0, flush_1}, 32'h1);
    quiet();
    step(1);
    check_eq("int_pulse_end", excepttype_o, 32'h0);
    check_eq("int_flush2", {31'd0, flush_o}, 32'h1);
    check_eq("int_newpc_hold", new_pc_o, 32'h40);
    check_eq("f1_flush_b", {31'd0, flush_1}, 32'h0);
    step(1);
    check_eq("int_flush_end", {31'd0, flush_o}, 32'h0);
    check_eq("int_idle", {31'd0, busy_o}, 32'h0);

    // EXL masks the interrupt, but a sync ri exception still fires.
    status_i = 32'h1000_ff03; int_i = 8'h04; valid_i = 1'b1; pc_i = 32'h100;
    step(1);
    check_eq("exl_masked", excepttype_o, 32'h0);
    check_eq("exl_noflush", {31'd0, flush_o}, 32'h0);
    exc_flags_i = 5'h02;
    step(1);
    check_eq("ri_code", excepttype_o, 32'ha);
    quiet();
    step(3);

    // Eret with same-cycle mtc0 to EPC.
    epc_i = 32'h200; wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'h0e; wb_cp0_wdata_i = 32'h300;
    exc_flags_i = 5'h10; valid_i = 1'b1;
    step(1);
    check_eq("eret_code", excepttype_o, 32'hd);
    check_eq("eret_newpc", new_pc_o, 32'h300);
    quiet();
    step(3);

    // ov + syscall in a delay slot; syscall held through FLUSH then re-accepted in IDLE.
    exc_flags_i = 5'h05; in_delay_slot_i = 1'b1; pc_i = 32'h204; valid_i = 1'b1;
    step(1);
    check_eq("ov_code", excepttype_o, 32'hb);
    check_eq("ov_ds", {31'd0, exc_delay_slot_o}, 32'h1);
    check_eq("ov_pc", exc_pc_o, 32'h204);
    exc_flags_i = 5'h01; in_delay_slot_i = 1'b0; pc_i = 32'h208;
    step(1);
    check_eq("flush_ignore", excepttype_o, 32'h0);
    step(1);
    check_eq("flush_done", {31'd0, flush_o}, 32'h0);
    check_eq("flush_done_ex", excepttype_o, 32'h0);
    step(1);
    check_eq("reaccept_code", excepttype_o, 32'h9);
    check_eq("reaccept_pc", exc_pc_o, 32'h208);
    quiet();
    step(3);

    // valid_i=0 hides the syscall.
    exc_flags_i = 5'h01; valid_i = 1'b0;
    step(1);
    check_eq("bubble_ignored", excepttype_o, 32'h0);
    check_eq("bubble_busy", {31'd0, busy_o}, 32'h0);

    // Interrupt pending via cause IP beats a simultaneous ri.
    cause_i = 32'h0000_0800; status_i = 32'h0000_ff01; exc_flags_i = 5'h02;
    pc_i = 32'h300; valid_i = 1'b1;
    step(1);
    check_eq("int_vs_ri", excepttype_o, 32'h4);
    check_eq("int_vs_ri_pc", exc_pc_o, 32'h300);
    quiet();
    step(3);

    // Timer interrupt drives line 7 -> code 8.
    status_i = 32'h0000_8001; timer_int_i = 1'b1; valid_i = 1'b1;
    step(1);
    check_eq("timer_code", excepttype_o, 32'h8);
    quiet();
    step(3);

    // Status bypass enables the interrupt; a non-CP0-status address does not.
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'h0b; wb_cp0_wdata_i = 32'h0000_0401;
    int_i = 8'h04; valid_i = 1'b1;
    step(1);
    check_eq("nobypass_addr", excepttype_o, 32'h0);
    wb_cp0_waddr_i = 5'h0c;
    step(1);
    check_eq("status_bypass", excepttype_o, 32'h3);
    quiet();
    step(3);

    // Async reset during FLUSH clears everything immediately.
    exc_flags_i = 5'h08; valid_i = 1'b1; pc_i = 32'h400;
    step(1);
    check_eq("trap_code", excepttype_o, 32'hc);
    quiet();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_flush", {31'd0, flush_o}, 32'h0);
    check_eq("midrst_busy", {31'd0, busy_o}, 32'h0);
    check_eq("midrst_pc", exc_pc_o, 32'h0);
    check_eq("midrst_newpc", new_pc_o, 32'h0);
    step(1);
    reset_n = 1'b1;
    step(1);
    check_eq("postrst_idle", {31'd0, busy_o}, 32'h0);
    exc_flags_i = 5'h01; valid_i = 1'b1;
    step(1);
    check_eq("postrst_event", excepttype_o, 32'h9);
    quiet();
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
